lfsr_count_decoder: RTL

Sequential decoder that maps an 8-bit LFSR state back to its step count N, the number of LFSR advances from a fixed seed. It is the inverse of the counter-to-LFSR-seed conversion used by the pattern-generation side of the test flow. The block sits on the response/analysis side of the BIST fixture, where it turns a captured LFSR value `dp` into a pattern index. It uses a start/busy/done handshake and runs a serial search.

---
 rtl/lfsr_count_decoder_if.sv | 20 ++
 rtl/lfsr_count_decoder.sv | 102 ++++++++++
 2 files changed

// File: rtl/lfsr_count_decoder_if.sv
// Start/busy/done handshake bundle for lfsr_count_decoder.
// master drives the request (start, dp); slave returns busy/done/n/err.
interface lfsr_count_decoder_if;
  logic       start;
  logic [7:0] dp;
  logic       busy;
  logic       done;
  logic [7:0] n;
  logic       err;

  modport master (
    output start, dp,
    input  busy, done, n, err
  );

  modport slave (
    input  start, dp,
    output busy, done, n, err
  );
endinterface

// File: rtl/lfsr_count_decoder.sv
// Serial decoder from an 8-bit LFSR state back to its step count from SEED.
// Optional search limit compiled in with macro LFSR_DEC_TIMEOUT_EN.
module lfsr_count_decoder #(
  parameter logic [7:0]  SEED      = 8'h01,
  parameter logic [7:0]  TAPS      = 8'hB8,
  parameter int unsigned MAX_STEPS = 255
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  lfsr_count_decoder_if.slave         bus
);

`ifdef LFSR_DEC_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  localparam logic [7:0] StepLimit = 8'(MAX_STEPS - 1);

  typedef enum logic {StIdle, StSearch} state_e;

  state_e     r_state;
  logic       r_start_q;
  logic [7:0] r_lfsr;
  logic [7:0] r_cnt;
  logic [7:0] r_target;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_n;
  logic       r_err;

  logic       w_start_edge;
  logic [7:0] w_lfsr_next;
  logic       w_match;
  logic       w_at_limit;

  assign w_start_edge = bus.start & ~r_start_q;
  assign w_lfsr_next  = {r_lfsr[6:0], ^(r_lfsr & TAPS)};
  assign w_match      = (r_lfsr == r_target);
  // Constant-folds away when the timeout is not compiled in.
  assign w_at_limit   = TimeoutEn && (r_cnt == StepLimit);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_start_q <= 1'b0;
      r_lfsr    <= SEED;
      r_cnt     <= 8'h00;
      r_target  <= 8'h00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_n       <= 8'h00;
      r_err     <= 1'b0;
    end else begin
      r_start_q <= bus.start;
      r_done    <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_start_edge) begin
            if (bus.dp != 8'h00) begin
              r_target <= bus.dp;
              r_lfsr   <= SEED;
              r_cnt    <= 8'h00;
              r_busy   <= 1'b1;
              r_state  <= StSearch;
            end else begin
              // Zero is never produced by the LFSR: report immediately.
              r_done <= 1'b1;
              r_err  <= 1'b1;
              r_n    <= 8'h00;
            end
          end
        end
        StSearch: begin
          if (w_match) begin
            r_n     <= r_cnt;
            r_err   <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else if (w_at_limit) begin
            r_n     <= r_cnt;
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_lfsr <= w_lfsr_next;
            r_cnt  <= r_cnt + 8'h01;
          end
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.n    = r_n;
  assign bus.err  = r_err;

endmodule
